// File: rtl/hc02_tester.sv
// Sequencer/checker for a quad 2-input NOR device (74HC02): sweeps all 256 A/B vectors,
// checks Y against ~(A|B). Define HC02_STOP_ON_FAIL_EN to stop at the first failing vector.
module hc02_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:1] a_out,
  output logic [4:1] b_out,
  input  logic [4:1] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:1] fail_mask,
  output logic [7:0] err_cnt
`ifdef HC02_STOP_ON_FAIL_EN
  ,
  output logic [7:0] fail_vec
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state;
  logic [7:0] vec;
  logic [7:0] settle_cnt;
  logic [4:1] y_meta;
  logic [4:1] y_sync;

  logic [4:1] exp_y;
  logic [4:1] mism;
  logic [7:0] err_inc;
  logic       any_mism;

  // NOTE: a single always_comb with every output defaulted first keeps this block latch-free.
  always_comb begin
    exp_y    = ~(a_out | b_out);
    mism     = y_sync ^ exp_y;
    any_mism = |mism;
    err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  end

  // Y_IN is asynchronous to clk; two flops bring it into this domain before comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_meta <= '0;
      y_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments so both flops sample their inputs on the same edge.
      y_meta <= y_in;
      y_sync <= y_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      a_out      <= '0;
      b_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      err_cnt    <= '0;
`ifdef HC02_STOP_ON_FAIL_EN
      fail_vec   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_APPLY;
            vec       <= '0;
            fail_mask <= '0;
            err_cnt   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef HC02_STOP_ON_FAIL_EN
            fail_vec  <= '0;
`endif
          end
        end
        S_APPLY: begin
          a_out      <= vec[7:4];
          b_out      <= vec[3:0];
          settle_cnt <= 8'(SETTLE_CYCLES);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd1) state <= S_CHECK;
          else settle_cnt <= settle_cnt - 8'd1;
        end
        S_CHECK: begin
          fail_mask <= fail_mask | mism;
`ifdef HC02_STOP_ON_FAIL_EN
          if (any_mism) begin
            // Freeze on the failing vector so the pins can be probed.
            fail_vec <= vec;
            err_cnt  <= 8'd1;
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
          end else if (vec == 8'hFF) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == 8'd0);
          end else begin
            vec   <= vec + 8'd1;
            state <= S_APPLY;
          end
`else
          if (any_mism) err_cnt <= err_inc;
          if (vec == 8'hFF) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == 8'd0) && !any_mism;
          end else begin
            vec   <= vec + 8'd1;
            state <= S_APPLY;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc02_tester.sv
// Directed bench for hc02_tester: loopback NOR model with injectable stuck-at faults.
module tb_hc02_tester;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:1] a_out, b_out, y_in;
  logic       busy, done, pass;
  logic [4:1] fail_mask;
  logic [7:0] err_cnt;
`ifdef HC02_STOP_ON_FAIL_EN
  logic [7:0] fail_vec;
`endif

  logic [4:1] stuck0 = '0;
  logic [4:1] stuck1 = '0;
  int checks = 0;
  int errors = 0;
  logic first_done;
  logic [7:0] first_err;

  assign y_in = (~(a_out | b_out) & ~stuck0) | stuck1;

  always #5 clk = ~clk;

  hc02_tester #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .err_cnt(err_cnt)
`ifdef HC02_STOP_ON_FAIL_EN
    , .fail_vec(fail_vec)
`endif
  );

  // Pulse START, then count edges until DONE; extra START pulses land while busy.
  task automatic run(input int pulses, output int cyc);
    int left;
    left = pulses;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    first_done = done;
    first_err  = err_cnt;
    while (cyc < 5000) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done) break;
      if (left > 0 && cyc % 50 == 0) begin
        start = 1'b1;
        left--;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if ({a_out, b_out, busy, done, pass, fail_mask, err_cnt} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", {a_out, b_out, busy, done, pass, fail_mask, err_cnt});
    end
  endtask

  task automatic test_good;
    int cyc;
    stuck0 = '0; stuck1 = '0;
    run(0, cyc);
    checks++;
    if (cyc !== 1536) begin errors++; $display("FAIL good_latency got %0d want 1536", cyc); end
    checks++;
    if ({pass, err_cnt, fail_mask, busy} !== {1'b1, 8'd0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL good_result pass=%b err=%0d mask=%b busy=%b want 1 0 0000 0", pass, err_cnt, fail_mask, busy);
    end
  endtask

  task automatic test_y3_stuck0;
    int cyc;
    stuck0 = 4'b0100; stuck1 = '0;
    run(0, cyc);
    checks++;
    if ({done, pass, err_cnt, fail_mask} !== {1'b1, 1'b0, 8'd64, 4'b0100}) begin
      errors++;
      $display("FAIL y3_stuck0 done=%b pass=%b err=%0d mask=%b want 1 0 64 0100", done, pass, err_cnt, fail_mask);
    end
    checks++;
    if ({a_out, b_out} !== 8'hFF) begin
      errors++;
      $display("FAIL last_vector_held got %h want ff", {a_out, b_out});
    end
  endtask

  task automatic test_y12_stuck1;
    int cyc;
    stuck0 = '0; stuck1 = 4'b0011;
    run(0, cyc);
    checks++;
    if ({pass, err_cnt, fail_mask} !== {1'b0, 8'd240, 4'b0011}) begin
      errors++;
      $display("FAIL y12_stuck1 pass=%b err=%0d mask=%b want 0 240 0011", pass, err_cnt, fail_mask);
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    stuck0 = 4'b1000; stuck1 = '0;
    run(10, cyc);
    checks++;
    if (cyc !== 1536) begin errors++; $display("FAIL busy_start_latency got %0d want 1536", cyc); end
    checks++;
    if ({err_cnt, fail_mask} !== {8'd64, 4'b1000}) begin
      errors++;
      $display("FAIL busy_start_result err=%0d mask=%b want 64 1000", err_cnt, fail_mask);
    end
    // Restart from DONE clears results on the next cycle.
    run(0, cyc);
    checks++;
    if ({first_done, first_err} !== 9'd0) begin
      errors++;
      $display("FAIL restart_clear done=%b err=%0d want 0 0", first_done, first_err);
    end
    checks++;
    if (cyc !== 1536 || err_cnt !== 8'd64) begin
      errors++;
      $display("FAIL restart_run cyc=%0d err=%0d want 1536 64", cyc, err_cnt);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    stuck0 = 4'b1000; stuck1 = '0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (602) @(posedge clk);
    #1;
    checks++;
    if ({a_out, b_out, busy, err_cnt} !== {4'h6, 4'h4, 1'b1, 8'd52}) begin
      errors++;
      $display("FAIL mid_run_state a=%h b=%h busy=%b err=%0d want 6 4 1 52", a_out, b_out, busy, err_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_out, b_out, busy, err_cnt} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset a=%h b=%h busy=%b err=%0d want 0 0 0 0", a_out, b_out, busy, err_cnt);
    end
    #2 rst = 1'b0;
    stuck0 = '0;
    run(0, cyc);
    checks++;
    if (cyc !== 1536 || {pass, err_cnt, fail_mask} !== {1'b1, 8'd0, 4'b0000}) begin
      errors++;
      $display("FAIL post_reset_run cyc=%0d pass=%b err=%0d mask=%b want 1536 1 0 0000", cyc, pass, err_cnt, fail_mask);
    end
  endtask

`ifdef HC02_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail;
    int cyc;
    stuck0 = '0; stuck1 = 4'b0001;
    run(0, cyc);
    checks++;
    if (cyc !== 12) begin errors++; $display("FAIL stop_latency got %0d want 12", cyc); end
    checks++;
    if ({fail_vec, err_cnt, fail_mask, pass} !== {8'h01, 8'd1, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL stop_result vec=%h err=%0d mask=%b pass=%b want 01 1 0001 0", fail_vec, err_cnt, fail_mask, pass);
    end
    checks++;
    if ({a_out, b_out} !== 8'h01) begin
      errors++;
      $display("FAIL stop_vector_held got %h want 01", {a_out, b_out});
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef HC02_STOP_ON_FAIL_EN
    test_good;
    test_stop_on_fail;
`else
    test_good;
    test_y3_stuck0;
    test_y12_stuck1;
    test_start_while_busy;
    test_reset_mid_run;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
